// File: rtl/nonrestoring_divider.sv
// Multi-cycle non-restoring divider: one quotient bit per cycle, then one fix-up cycle.
// Optional two's-complement mode is enabled by defining SIGNED_DIV_EN.
module nonrestoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic             dbz_q;
`ifdef SIGNED_DIV_EN
    logic             neg_q_q;
    logic             neg_r_q;
`endif

    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   r_step_d;
    logic [WIDTH-1:0] q_step_d;
    logic [WIDTH-1:0] rem_fix_d;
    logic [WIDTH-1:0] quo_fix_d;
    logic [WIDTH-1:0] a_mag_d;
    logic [WIDTH-1:0] b_mag_d;

    always_comb begin
        r_sh      = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        r_step_d  = r_q[WIDTH] ? (r_sh + {1'b0, d_q}) : (r_sh - {1'b0, d_q});
        q_step_d  = {q_q[WIDTH-2:0], ~r_step_d[WIDTH]};
        // The true remainder is below the divisor, so WIDTH bits suffice
        rem_fix_d = r_q[WIDTH-1:0] + (r_q[WIDTH] ? d_q : '0);
        quo_fix_d = q_q;
        a_mag_d   = dividend;
        b_mag_d   = divisor;
`ifdef SIGNED_DIV_EN
        if (neg_q_q) quo_fix_d = -q_q;
        if (neg_r_q) rem_fix_d = -rem_fix_d;
        if (dividend[WIDTH-1]) a_mag_d = -dividend;
        if (divisor[WIDTH-1]) b_mag_d = -divisor;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        cnt_q  <= '0;
                        r_q    <= '0;
                        q_q    <= a_mag_d;
                        d_q    <= b_mag_d;
`ifdef SIGNED_DIV_EN
                        neg_q_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r_q <= dividend[WIDTH-1];
`endif
                        if (divisor == '0) begin
                            quo_q   <= '1;
                            rem_q   <= dividend;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_q   <= r_step_d;
                    q_q   <= q_step_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
                end
                FIX: begin
                    quo_q   <= quo_fix_d;
                    rem_q   <= rem_fix_d;
                    dbz_q   <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/nonrestoring_divider.md
NONRESTORING_DIVIDER -- requirements
Module: nonrestoring_divider

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 start  input  1  SHALL request a division; it is sampled only in IDLE.
REQ-005 dividend  input  WIDTH  SHALL be the dividend, captured on the edge that accepts start.
REQ-006 divisor  input  WIDTH  SHALL be the divisor, captured on the edge that accepts start.
REQ-007 busy  output  1  SHALL be high in every state except IDLE.
REQ-008 done  output  1  SHALL be a one-cycle pulse marking valid results.
REQ-009 quotient  output  WIDTH  SHALL carry the quotient.
REQ-010 remainder  output  WIDTH  SHALL carry the remainder.
REQ-011 div_by_zero  output  1  SHALL flag that the divisor was zero for the current result.

Function
REQ-012 The FSM SHALL have exactly these states: IDLE, CALC, FIX, DONE.
REQ-013 In IDLE, start=1 SHALL capture both operands, clear the step counter and enter CALC; divisor=0 SHALL enter DONE directly.
REQ-014 CALC SHALL perform one non-restoring step per cycle for exactly WIDTH cycles:
  - partial remainder R (WIDTH+1 bits, signed) shifts left by one, taking in the next dividend MSB;
  - R>=0 before the step: subtract the divisor; otherwise: add the divisor;
  - the quotient bit is the inverse of the new R sign bit.
REQ-015 FIX SHALL take one cycle and add the divisor back to R when R<0, then enter DONE.
REQ-016 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-017 Latency SHALL be fixed: done is high in the cycle after the (WIDTH+2)th rising edge counted from the edge that accepted start, including that edge.
REQ-018 Divide-by-zero SHALL produce quotient all ones, remainder = dividend and div_by_zero=1, with done after the 1st edge following acceptance.
REQ-019 quotient, remainder and div_by_zero SHALL hold their values from DONE until the next accepted start.
REQ-020 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-021 start held high continuously SHALL launch a new operation on the first IDLE cycle after DONE.
REQ-022 Operands changing while busy SHALL NOT affect the result.

Reset
REQ-023 rst=1 SHALL immediately force IDLE and clear busy, done, quotient, remainder, div_by_zero and all internal registers to zero.
REQ-024 Reset asserted mid-operation SHALL abort the division; no done pulse SHALL follow.
REQ-025 After release, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-026 With macro SIGNED_DIV_EN defined, operands and results SHALL be two's complement:
  - divide magnitudes, then negate the quotient when the operand signs differ;
  - the remainder SHALL take the dividend's sign (truncation toward zero);
  - most-negative / -1 SHALL return quotient = most-negative value and remainder 0;
  - latency SHALL stay as in REQ-017, with sign handling absorbed into the capture and FIX cycles.
REQ-027 Without SIGNED_DIV_EN, operands and results SHALL be unsigned and no sign logic SHALL be synthesized.

Verification (WIDTH=8)
REQ-028 Unsigned: dividend=100, divisor=7, start for 1 cycle -> done at edge+10 with quotient=14, remainder=2, div_by_zero=0.
REQ-029 Boundary: 255/1 -> quotient=255, remainder=0; 5/9 -> quotient=0, remainder=5; 255/255 -> quotient=1, remainder=0.
REQ-030 Zero divisor: 37/0 -> done 1 cycle after acceptance, quotient=0xFF, remainder=37, div_by_zero=1.
REQ-031 Busy rules: start=1 with 9/3 at cycle 3 of 100/7 -> result is still 14 r 2, and exactly one done pulse occurs.
REQ-032 Reset: rst pulsed at cycle 4 of a division -> all outputs 0, no done; the next division 50/5 -> 10 r 0.
REQ-033 SIGNED_DIV_EN: -100/7 -> quotient=0xF2, remainder=0xFE; -128/-1 -> quotient=0x80, remainder=0.
